uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receive side of the UART link; the counterpart of the transmit shift register.
//  Oversamples the asynchronous serial line and detects the start bit.
//  Shifts in WIDTH data bits, MSB first, matching the transmitter's shift order.
//  Checks optional parity and the stop bit, then presents a parallel word with a one-cycle valid strobe.
// PARAMETERS
//  WIDTH       8   data bits per frame
//  OVERSAMPLE  16  en ticks per bit period; even, >=4
//  PARITY_EN   1   1: a parity bit follows the data; 0: no parity bit
//  PARITY_ODD  0   0: even parity; 1: odd parity (ignored when PARITY_EN=0)
// PORTS
//  clk         in   1      single clock; all state on posedge
//  rst_n       in   1      asynchronous reset, active-low
//  en          in   1      oversample tick; all counters and the FSM advance only when high
//  rx_in       in   1      asynchronous serial line; idles high
//  d_out       out  WIDTH  last received word; held until the next frame completes
//  d_valid     out  1      one-clk pulse; new d_out, parity_err and frame_err are valid
//  parity_err  out  1      qualified by d_valid: received parity mismatches computed parity
//  frame_err   out  1      qualified by d_valid: stop bit sampled low
//  busy        out  1      high from start-bit detect until return to IDLE
// BEHAVIOUR
//  Reset: d_out=0, d_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, synchroniser=1'b1.
//  rx_in goes through a 2-flop synchroniser (2 clk latency); the FSM uses only the synchronised value.
//  en=0: tick counter, bit counter, shift register and FSM hold. d_valid is never asserted when en=0.
//  tick_cnt counts 0..OVERSAMPLE-1 and is cleared on every state entry.
//  IDLE:   requires armed=1, meaning the line was seen high since the last frame.
//          rx=0 with en=1 -> START; busy=1.
//  START:  at tick_cnt=OVERSAMPLE/2-1 (mid-bit), sample the line:
//          rx=1 (glitch) -> IDLE, busy=0, no outputs.
//          rx=0 -> DATA; bit_cnt=0.
//  DATA:   every OVERSAMPLE ticks, sample at mid-bit; shift={shift[WIDTH-2:0],rx}.
//          After WIDTH samples -> PARITY if PARITY_EN, else STOP.
//  PARITY: sample at mid-bit; perr = rx ^ (^shift) ^ PARITY_ODD.
//  STOP:   sample at mid-bit. On the same clk edge:
//          d_out<=shift, frame_err<=~rx, parity_err<=perr (0 if !PARITY_EN), d_valid<=1.
//          FSM -> IDLE, busy<=0, armed<=rx.
//  d_valid, parity_err and frame_err are single-clk pulses; they return to 0 on the next clk.
//  Latency: d_valid rises 1 clk after the en tick that samples the middle of the stop bit.
//  Frame errors and parity errors still deliver the data word (d_out updated); downstream decides.
//  Break (line held low): after frame_err, IDLE stays disarmed until rx=1 is seen.
//          No spurious frames are received while the line stays low.
//  Reset mid-frame: the frame is abandoned and all outputs go to reset values immediately.
//          No d_valid for the partial frame.
//  bit_cnt width: $clog2(WIDTH+1). tick_cnt width: $clog2(OVERSAMPLE).
// STRUCTURE
//  uart_pkg: rx state enum (IDLE, START, DATA, PARITY, STOP) and a parity function.
//          The parity function is shared with the transmit path.
//  One sub-module: sync_2ff (1-bit synchroniser, reset value parameterised to 1).
//  All other logic is inline: FSM, tick/bit counters, shift register, output registers.
// TESTING  (OVERSAMPLE=16, en=1 every clk unless stated)
//  1. Frame 0 A5 0 1 (start, data MSB-first, even parity, stop):
//     -> d_out=8'hA5, one d_valid pulse, parity_err=0, frame_err=0.
//  2. Data 8'h01 sent with parity bit 0 (even parity requires 1):
//     -> d_out=8'h01, d_valid=1, parity_err=1, frame_err=0.
//  3. Data 8'h3C with stop bit 0, then line low for 3 bit times, then idle high, then frame 8'hC3:
//     -> first frame gives frame_err=1; only 2 d_valid pulses in total; second word 8'hC3, errors 0.
//  4. rx_in low for 4 ticks, then high:
//     -> busy pulses then returns to 0; no d_valid; the next valid frame is received correctly.
//  5. rst_n asserted during data bit 4, released, then frame 8'h5A:
//     -> outputs 0 during reset; no d_valid for the partial frame; then d_out=8'h5A.
//  6. en high every other clk, frame 8'hA5:
//     -> same result as test 1; d_valid still 1 clk wide; frame duration doubles in clk cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and parity helper
//
// Purpose: receive FSM state encoding and the parity function used by both
// the receive and transmit paths.
// Ports: none (package).

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Widest data word the parity helper accepts; narrower words are
  // zero-extended, which leaves the XOR reduction unchanged.
  localparam int PARITY_MAX_WIDTH = 32;

  // Parity bit a transmitter appends to 'data': even parity makes the total
  // count of ones even, odd parity makes it odd.
  function automatic logic parity_of(input logic [PARITY_MAX_WIDTH-1:0] data,
                                     input logic                        odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous bit
//
// Purpose: bring an asynchronous level into the clk domain (2 clk latency).
// Ports:
//   clk    in  1  sampling clock
//   rst_n  in  1  asynchronous reset, active-low; both flops load RESET_VAL
//   d      in  1  asynchronous input
//   q      out 1  synchronised output

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, MSB first, optional parity
//
// Purpose: detect a start bit on the serial line, sample WIDTH data bits, an
// optional parity bit and the stop bit at mid-bit, then present the word with
// a one-clk valid strobe and error flags.
// Ports:
//   clk         in  1      single clock
//   rst_n       in  1      asynchronous reset, active-low
//   en          in  1      oversample tick; all sequencing advances only when high
//   rx_in       in  1      asynchronous serial line, idles high
//   d_out       out WIDTH  last received word, held until the next frame completes
//   d_valid     out 1      one-clk pulse marking a new d_out and error flags
//   parity_err  out 1      parity mismatch, qualified by d_valid
//   frame_err   out 1      stop bit sampled low, qualified by d_valid
//   busy        out 1      high from start-bit detect until back in IDLE

module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rx_in,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH + 1);

  // START samples half a bit after detection; every later state samples one
  // full bit period after the previous sample, which lands at mid-bit again.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  logic rx;

  rx_state_t        state,    state_nxt;
  logic [TW-1:0]    tick_cnt, tick_nxt;
  logic [BW-1:0]    bit_cnt,  bit_nxt;
  logic [WIDTH-1:0] shift,    shift_nxt;
  logic             perr,     perr_nxt;
  logic             armed,    armed_nxt;
  logic [WIDTH-1:0] d_out_nxt;
  logic             d_valid_nxt;
  logic             parity_err_nxt;
  logic             frame_err_nxt;
  logic             busy_nxt;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (rx)
  );

  always_comb begin
    state_nxt      = state;
    tick_nxt       = tick_cnt;
    bit_nxt        = bit_cnt;
    shift_nxt      = shift;
    perr_nxt       = perr;
    armed_nxt      = armed;
    d_out_nxt      = d_out;
    d_valid_nxt    = 1'b0;
    parity_err_nxt = 1'b0;
    frame_err_nxt  = 1'b0;

    if (en) begin
      tick_nxt = tick_cnt + TW'(1);
      case (state)
        IDLE: begin
          tick_nxt = '0;
          // A low line only starts a frame once it has been seen high since
          // the last frame; this keeps a held-low break from retriggering.
          if (rx) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            state_nxt = START;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt = '0;
            if (rx) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              bit_nxt   = '0;
              perr_nxt  = 1'b0;
            end
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            shift_nxt = {shift[WIDTH-2:0], rx};
            bit_nxt   = bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            perr_nxt  = rx ^ parity_of(PARITY_MAX_WIDTH'(shift), PARITY_ODD != 0);
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt       = '0;
            d_out_nxt      = shift;
            frame_err_nxt  = ~rx;
            parity_err_nxt = (PARITY_EN != 0) ? perr : 1'b0;
            d_valid_nxt    = 1'b1;
            armed_nxt      = rx;
            state_nxt      = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      perr       <= 1'b0;
      armed      <= 1'b0;
      d_out      <= '0;
      d_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      perr       <= perr_nxt;
      armed      <= armed_nxt;
      d_out      <= d_out_nxt;
      d_valid    <= d_valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;

  localparam int WIDTH = 8;
  localparam int OS    = 16;
  localparam int PEN   = 1;
  localparam int PODD  = 0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             rx_in;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             parity_err;
  logic             frame_err;
  logic             busy;

  uart_rx #(
    .WIDTH     (WIDTH),
    .OVERSAMPLE(OS),
    .PARITY_EN (PEN),
    .PARITY_ODD(PODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rx_in     (rx_in),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             perr;
    logic             ferr;
    int               cyc;
  } frame_t;

  frame_t obs_q[$];
  frame_t exp_q[$];

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   wide_cnt  = 0;
  logic prev_dv   = 1'b0;
  logic busy_seen = 1'b0;
  bit   half_rate = 1'b0;

  always @(posedge clk) cyc++;

  initial begin
    en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      en = half_rate ? ~en : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (d_valid) obs_q.push_back('{d_out, parity_err, frame_err, cyc});
    if (d_valid && prev_dv) wide_cnt++;
    prev_dv = d_valid;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference: the transmitter's correct parity bit, and the receiver's
  // verdict on an arbitrary frame, from counting ones.
  function automatic logic good_pbit(input logic [WIDTH-1:0] d);
    return logic'(($countones(d) + PODD) % 2);
  endfunction

  function automatic frame_t model(input logic [WIDTH-1:0] d, input logic pbit, input logic stop);
    frame_t f;
    f.data = d;
    f.perr = (PEN != 0) ? ((($countones(d) + int'(pbit) + PODD) % 2) != 0) : 1'b0;
    f.ferr = !stop;
    f.cyc  = 0;
    return f;
  endfunction

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (en) k++;
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(d[i]);
    if (PEN != 0) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic expect_frame(input logic [WIDTH-1:0] d, input logic pbit, input logic stop);
    exp_q.push_back(model(d, pbit, stop));
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic compare_all(input string tag);
    frame_t o;
    frame_t e;
    int     idx = 0;
    wait_obs(exp_q.size(), 2000);
    chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]_data", tag, idx), 32'(o.data), 32'(e.data));
      chk($sformatf("%s[%0d]_parity_err", tag, idx), 32'(o.perr), 32'(e.perr));
      chk($sformatf("%s[%0d]_frame_err", tag, idx), 32'(o.ferr), 32'(e.ferr));
      idx++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk($sformatf("%s_d_out", tag), 32'(d_out), 32'h0);
    chk($sformatf("%s_d_valid", tag), 32'(d_valid), 32'h0);
    chk($sformatf("%s_parity_err", tag), 32'(parity_err), 32'h0);
    chk($sformatf("%s_frame_err", tag), 32'(frame_err), 32'h0);
    chk($sformatf("%s_busy", tag), 32'(busy), 32'h0);
  endtask

  initial begin
    int               start_cyc;
    int               lat;
    logic [WIDTH-1:0] d;
    logic             pb;
    logic             st;
    int               gap;

    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_reset("reset");
    rst_n = 1'b1;
    wait_ticks(2 * OS);

    // 1: clean frame A5 with even parity; exact latency from start edge
    start_cyc = cyc;
    expect_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_obs(1, 2000);
    lat = (obs_q.size() > 0) ? obs_q[0].cyc - start_cyc : -1;
    chk("t1_latency", lat, 3 + OS / 2 + OS * (WIDTH + PEN + 1));
    compare_all("t1");
    chk("t1_pulse_width", wide_cnt, 0);

    // 2: wrong parity bit still delivers the word
    expect_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1);
    send_bit(1'b1);
    compare_all("t2");

    // 3: framing error followed by a break, then a good frame
    expect_frame(8'h3C, good_pbit(8'h3C), 1'b0);
    send_frame(8'h3C, good_pbit(8'h3C), 1'b0);
    repeat (3) send_bit(1'b0);
    repeat (2) send_bit(1'b1);
    expect_frame(8'hC3, good_pbit(8'hC3), 1'b1);
    send_frame(8'hC3, good_pbit(8'hC3), 1'b1);
    send_bit(1'b1);
    compare_all("t3");

    // 4: short glitch is rejected, next frame is received
    busy_seen = 1'b0;
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(2 * OS);
    chk("t4_busy_pulsed", 32'(busy_seen), 32'h1);
    chk("t4_busy_idle", 32'(busy), 32'h0);
    chk("t4_no_valid", obs_q.size(), 0);
    d = WIDTH'($urandom_range(1, 255));
    expect_frame(d, good_pbit(d), 1'b1);
    send_frame(d, good_pbit(d), 1'b1);
    send_bit(1'b1);
    compare_all("t4");

    // 5: reset during data bit 4 abandons the frame
    d = 8'h96;
    send_bit(1'b0);
    send_bit(d[7]);
    send_bit(d[6]);
    send_bit(d[5]);
    rx_in = d[4];
    wait_ticks(OS / 2);
    rst_n = 1'b0;
    #1;
    chk_outputs_reset("t5_in_reset");
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_reset("t5_held_reset");
    rst_n = 1'b1;
    wait_ticks(2 * OS);
    chk("t5_no_partial", obs_q.size(), 0);
    expect_frame(8'h5A, good_pbit(8'h5A), 1'b1);
    send_frame(8'h5A, good_pbit(8'h5A), 1'b1);
    send_bit(1'b1);
    compare_all("t5");

    // 6: en every other clk doubles the frame time
    half_rate = 1'b1;
    wait_ticks(2);
    start_cyc = cyc;
    expect_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_obs(1, 4000);
    lat = (obs_q.size() > 0) ? obs_q[0].cyc - start_cyc : -1;
    chk("t6_latency_doubled", 32'(lat >= 336 && lat <= 346), 32'h1);
    compare_all("t6");
    chk("t6_pulse_width", wide_cnt, 0);
    half_rate = 1'b0;
    wait_ticks(2 * OS);

    // random frames with occasional parity and stop errors
    for (int n = 0; n < 12; n++) begin
      d   = WIDTH'($urandom);
      pb  = good_pbit(d) ^ ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(1, 3);
      expect_frame(d, pb, st);
      send_frame(d, pb, st);
      repeat (gap) send_bit(1'b1);
    end
    compare_all("rand");
    chk("final_pulse_width", wide_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
